main_mem_responder: RTL and testbench

MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

---
 rtl/mem_pkg.sv | 19 +
 rtl/main_mem_responder_if.sv | 25 ++
 rtl/main_mem_responder_line_ram.sv | 26 ++
 rtl/main_mem_responder.sv | 104 ++++++++++
 tb/tb_main_mem_responder.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared constants, FSM encoding and line helpers for the main-memory responder.
package mem_pkg;
    localparam int BLOCK_WORDS     = 4;
    localparam int WORD_W          = 32;
    localparam int LINE_W          = BLOCK_WORDS * WORD_W;
    localparam int DEFAULT_LATENCY = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2,
        S_WDONE = 2'd3
    } state_t;

    function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                    input logic [1:0]        idx);
        return line[32*idx +: WORD_W];
    endfunction
endpackage

// File: rtl/main_mem_responder_if.sv
// Cache <-> main memory line-transfer bus: one request channel, one refill/ack channel.
interface main_mem_responder_if;
    import mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [LINE_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [WORD_W-1:0] rsp_data;
    logic [1:0]        rsp_idx;
    logic              rsp_last;
    logic              wr_done;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data, rsp_idx, rsp_last, wr_done
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data, rsp_idx, rsp_last, wr_done
    );
endinterface

// File: rtl/main_mem_responder_line_ram.sv
// Single-port line store: one read or one write per cycle, registered read data.
module line_ram #(
    parameter  int DEPTH = 256,
    parameter  int WIDTH = 128,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // No reset: contents must survive rst.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem_q[addr] <= wdata;
            else    rdata_q     <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/main_mem_responder.sv
// Fixed-latency main-memory model: accepts one line request at a time, then
// either streams the line back as four words or acknowledges a write-back.
module main_mem_responder
    import mem_pkg::*;
#(
    parameter int LATENCY     = DEFAULT_LATENCY,
    parameter int DEPTH_LINES = 256
) (
    input logic                 clk,
    input logic                 rst,
    main_mem_responder_if.slave bus
);
    localparam int         IDX_W  = $clog2(DEPTH_LINES);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        beat_q, beat_d;
    logic              we_q, we_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              ram_en, ram_we;
    logic [LINE_W-1:0] ram_rdata, cur_line;
    logic              unused_addr;

    assign unused_addr = ^{bus.req_addr[31:IDX_W+4], bus.req_addr[3:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        we_d    = we_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        line_d  = line_q;
        ram_en  = 1'b0;
        ram_we  = 1'b0;
        case (state_q)
            S_IDLE: if (bus.req_valid) begin
                state_d = S_WAIT;
                cnt_d   = LAT_M1;
                we_d    = bus.req_we;
                idx_d   = bus.req_addr[IDX_W+3:4];
                wdata_d = bus.req_wdata;
            end
            // The RAM access lands on the WAIT-exit edge: write commits, read data registers.
            S_WAIT: if (cnt_q == 4'd0) begin
                ram_en  = 1'b1;
                ram_we  = we_q;
                beat_d  = 2'd0;
                state_d = we_q ? S_WDONE : S_BURST;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            S_BURST: begin
                if (beat_q == 2'd0) line_d = ram_rdata;
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) state_d = S_IDLE;
            end
            S_WDONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            line_q  <= line_d;
        end
    end

    // Gating with rst drops a write-back whose commit edge coincides with reset.
    line_ram #(.DEPTH(DEPTH_LINES), .WIDTH(LINE_W)) u_ram (
        .clk   (clk),
        .en    (ram_en & ~rst),
        .we    (ram_we),
        .addr  (idx_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // Word 0 comes straight from the RAM register while the buffer is filling.
    assign cur_line      = (beat_q == 2'd0) ? ram_rdata : line_q;
    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_BURST);
    assign bus.rsp_data  = bus.rsp_valid ? line_word(cur_line, beat_q) : '0;
    assign bus.rsp_idx   = bus.rsp_valid ? beat_q : 2'd0;
    assign bus.rsp_last  = bus.rsp_valid && (beat_q == 2'd3);
    assign bus.wr_done   = (state_q == S_WDONE);
endmodule

// File: tb/tb_main_mem_responder.sv
// Randomized self-checking bench for main_mem_responder against a line-array model.
module tb_main_mem_responder;
    import mem_pkg::*;

    localparam int LAT   = 4;
    localparam int DEPTH = 256;
    localparam int IDX_W = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic [LINE_W-1:0] model [DEPTH];
    int                known[$];

    main_mem_responder_if bus ();

    main_mem_responder #(.LATENCY(LAT), .DEPTH_LINES(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int lidx(input logic [31:0] a);
        return int'((a >> 4) % DEPTH);
    endfunction

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL ready_timeout: req_ready=%b required 1 within 64 cycles", bus.req_ready);
        end
    endtask

    task automatic write_txn(input logic [31:0] addr, input logic [LINE_W-1:0] data,
                             output int done_cyc, output int pulses, output int low_cnt);
        bit ok, seen_high;
        done_cyc = -1; pulses = 0; low_cnt = 0; seen_high = 1'b0;
        wait_ready(ok);
        if (!ok) return;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = addr; bus.req_wdata = data;
        for (int k = 1; k <= LAT + 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.req_valid = 1'b0;
                bus.req_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            if (bus.wr_done === 1'b1) begin
                pulses++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (!seen_high) begin
                if (bus.req_ready !== 1'b1) low_cnt++;
                else seen_high = 1'b1;
            end
        end
    endtask

    task automatic read_txn(input logic [31:0] addr, output logic [LINE_W-1:0] line,
                            output int first, output int nbeats, output int bad);
        bit ok;
        line = '0; first = -1; nbeats = 0; bad = 0;
        wait_ready(ok);
        if (!ok) return;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = addr;
        for (int k = 1; k <= LAT + 10; k++) begin
            @(negedge clk);
            if (k == 1) bus.req_valid = 1'b0;
            if (bus.wr_done !== 1'b0) bad++;
            if (bus.rsp_valid === 1'b1) begin
                if (first < 0) first = k;
                if (k != first + nbeats || bus.rsp_idx !== 2'(nbeats) ||
                    bus.rsp_last !== (nbeats == 3)) bad++;
                if (nbeats < 4) line[32*nbeats +: 32] = bus.rsp_data;
                nbeats++;
            end else if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== '0 ||
                         bus.rsp_idx !== 2'd0 || bus.rsp_last !== 1'b0) begin
                bad++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_data !== '0 ||
            bus.rsp_idx !== 2'd0 || bus.rsp_last !== 1'b0 || bus.wr_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: ready=%b rsp_valid=%b data=%h idx=%0d last=%b wr_done=%b required 1 0 0 0 0 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_idx, bus.rsp_last, bus.wr_done);
        end
        rst = 1'b0;
    endtask

    task automatic test_spec_vectors();
        int dc, pl, lo, first, nb, bad;
        logic [LINE_W-1:0] wl, got;
        wl = {32'd4, 32'd3, 32'd2, 32'd1};
        write_txn(32'h30, wl, dc, pl, lo);
        model[lidx(32'h30)] = wl; known.push_back(lidx(32'h30));
        checks++;
        if (dc != LAT + 1 || pl != 1) begin
            failures++;
            $display("FAIL write_timing: wr_done at %0d x%0d required at %0d x1", dc, pl, LAT + 1);
        end
        checks++;
        if (lo != LAT + 1) begin
            failures++;
            $display("FAIL write_ready_low: low %0d cycles required %0d", lo, LAT + 1);
        end
        read_txn(32'h3C, got, first, nb, bad);
        checks++;
        if (first != LAT + 1 || nb != 4 || bad != 0) begin
            failures++;
            $display("FAIL read_timing: first=%0d beats=%0d bad=%0d required %0d 4 0", first, nb, bad, LAT + 1);
        end
        checks++;
        if (got !== wl) begin
            failures++;
            $display("FAIL read_data: got %h required %h", got, wl);
        end
        read_txn(32'h30 + 16 * DEPTH, got, first, nb, bad);
        checks++;
        if (got !== wl || nb != 4 || bad != 0) begin
            failures++;
            $display("FAIL read_wrap: got %h beats=%0d bad=%0d required %h 4 0", got, nb, bad, wl);
        end
    endtask

    task automatic test_random();
        int dc, pl, lo, first, nb, bad, w;
        logic [31:0] a;
        logic [LINE_W-1:0] d, got;
        for (int it = 0; it < 24; it++) begin
            a = $urandom;
            if (known.size() == 0 || $urandom_range(0, 1) == 0) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                write_txn(a, d, dc, pl, lo);
                model[lidx(a)] = d; known.push_back(lidx(a));
                checks++;
                if (dc != LAT + 1 || pl != 1 || lo != LAT + 1) begin
                    failures++;
                    $display("FAIL rand_write %0d: done=%0d pulses=%0d low=%0d required %0d 1 %0d",
                             it, dc, pl, lo, LAT + 1, LAT + 1);
                end
            end else begin
                w = known[$urandom_range(0, known.size() - 1)];
                a[IDX_W+3:4] = IDX_W'(w);
                read_txn(a, got, first, nb, bad);
                checks++;
                if (got !== model[w] || first != LAT + 1 || nb != 4 || bad != 0) begin
                    failures++;
                    $display("FAIL rand_read %0d: line %0d got %h first=%0d beats=%0d bad=%0d required %h %0d 4 0",
                             it, w, got, first, nb, bad, model[w], LAT + 1);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0]       addrs[4];
        logic [LINE_W-1:0] data[4];
        int                acc[$];
        logic [WORD_W-1:0] words[$];
        int                n, dones, overlap, gap_bad, word_bad;
        bit                ok;
        for (int i = 0; i < 4; i++) begin
            addrs[i] = $urandom;
            addrs[i][IDX_W+3:4] = IDX_W'(100 + 5 * i);
            data[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        // Writes with req_valid held high; garbage reads presented while busy.
        wait_ready(ok);
        n = 0; dones = 0; bus.req_valid = 1'b1;
        for (int c = 0; c < 4 * (LAT + 2) + 6; c++) begin
            if (bus.wr_done === 1'b1) dones++;
            if (bus.req_ready === 1'b1) begin
                if (n < 4) begin
                    bus.req_we = 1'b1; bus.req_addr = addrs[n]; bus.req_wdata = data[n];
                    acc.push_back(c); n++;
                end else bus.req_valid = 1'b0;
            end else begin
                bus.req_we = 1'b0; bus.req_addr = $urandom;
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            model[lidx(addrs[i])] = data[i]; known.push_back(lidx(addrs[i]));
        end
        gap_bad = 0;
        for (int i = 1; i < acc.size(); i++) if (acc[i] - acc[i-1] != LAT + 2) gap_bad++;
        checks++;
        if (acc.size() != 4 || gap_bad != 0 || dones != 4) begin
            failures++;
            $display("FAIL b2b_write: accepts=%0d bad_gaps=%0d dones=%0d required 4 0 4", acc.size(), gap_bad, dones);
        end
        // Reads with req_valid held high; garbage writes presented while busy.
        acc.delete();
        n = 0; overlap = 0; bus.req_valid = 1'b1;
        for (int c = 0; c < 4 * (LAT + 5) + 6; c++) begin
            if (bus.rsp_valid === 1'b1) begin
                words.push_back(bus.rsp_data);
                if (bus.req_ready === 1'b1) overlap++;
            end
            if (bus.req_ready === 1'b1) begin
                if (n < 4) begin
                    bus.req_we = 1'b0; bus.req_addr = addrs[n];
                    acc.push_back(c); n++;
                end else bus.req_valid = 1'b0;
            end else begin
                bus.req_we = 1'b1; bus.req_addr = $urandom;
                bus.req_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        gap_bad = 0;
        for (int i = 1; i < acc.size(); i++) if (acc[i] - acc[i-1] != LAT + 5) gap_bad++;
        checks++;
        if (acc.size() != 4 || gap_bad != 0 || overlap != 0) begin
            failures++;
            $display("FAIL b2b_read: accepts=%0d bad_gaps=%0d overlap=%0d required 4 0 0", acc.size(), gap_bad, overlap);
        end
        word_bad = 0;
        if (words.size() != 16) word_bad = 99;
        else for (int i = 0; i < 16; i++)
            if (words[i] !== model[lidx(addrs[i/4])][32*(i%4) +: 32]) word_bad++;
        checks++;
        if (word_bad != 0) begin
            failures++;
            $display("FAIL b2b_order: words=%0d bad=%0d required 16 0", words.size(), word_bad);
        end
    endtask

    task automatic test_rst_burst();
        int w, first, nb, bad, stray;
        bit ok;
        logic [LINE_W-1:0] got;
        w = known[0];
        wait_ready(ok);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'(w) << 4;
        for (int k = 1; k <= LAT + 2; k++) begin
            @(negedge clk);
            if (k == 1) bus.req_valid = 1'b0;
        end
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_idx !== 2'd1) begin
            failures++;
            $display("FAIL rst_burst_pre: rsp_valid=%b idx=%0d required 1 1", bus.rsp_valid, bus.rsp_idx);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.rsp_data !== '0) begin
            failures++;
            $display("FAIL rst_burst_post: rsp_valid=%b ready=%b data=%h required 0 1 0",
                     bus.rsp_valid, bus.req_ready, bus.rsp_data);
        end
        stray = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0 || bus.wr_done !== 1'b0) stray++;
        end
        read_txn(32'(w) << 4, got, first, nb, bad);
        checks++;
        if (stray != 0 || got !== model[w] || nb != 4 || bad != 0) begin
            failures++;
            $display("FAIL rst_burst_reread: stray=%0d got %h required %h", stray, got, model[w]);
        end
    endtask

    task automatic test_rst_wait();
        int dc, pl, lo, first, nb, bad, stray;
        bit ok;
        logic [LINE_W-1:0] old_l, got;
        old_l = {4{32'hAAAA_AAAA}};
        write_txn(32'h50, old_l, dc, pl, lo);
        model[lidx(32'h50)] = old_l;
        // Reset lands in the last WAIT cycle, right before the commit edge.
        wait_ready(ok);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h50;
        bus.req_wdata = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            if (k == 1) bus.req_valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.wr_done !== 1'b0 || bus.req_ready !== 1'b1) stray++;
            @(negedge clk);
        end
        read_txn(32'h50, got, first, nb, bad);
        checks++;
        if (stray != 0 || got !== old_l || bad != 0) begin
            failures++;
            $display("FAIL rst_wait: stray=%0d got %h required %h", stray, got, old_l);
        end
    endtask

    task automatic test_rst_priority();
        int first, nb, bad, stray;
        bit ok;
        logic [LINE_W-1:0] got;
        wait_ready(ok);
        rst = 1'b1;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h50;
        bus.req_wdata = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        rst = 1'b0; bus.req_valid = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_priority_ready: ready=%b required 1", bus.req_ready);
        end
        stray = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.wr_done !== 1'b0 || bus.rsp_valid !== 1'b0) stray++;
        end
        read_txn(32'h50, got, first, nb, bad);
        checks++;
        if (stray != 0 || got !== model[lidx(32'h50)]) begin
            failures++;
            $display("FAIL rst_priority_data: stray=%0d got %h required %h", stray, got, model[lidx(32'h50)]);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        test_reset();
        test_spec_vectors();
        test_random();
        test_back_to_back();
        test_rst_burst();
        test_rst_wait();
        test_rst_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
